memory_bus_ws: RTL and testbench
================================

Name: memory_bus_ws

Overview:
Parametrised successor to the fixed four-bank memory decoder. It routes CPU accesses to NUM_BANKS = 2^BANK_BITS banks selected by the top address bits. Each bank gets a programmable fixed wait-state count and an external ready input, so slow banks (SPI EEPROM/flash, peripherals) can stall the CPU. Adds read-only bank protection, an access timeout, and a bus_error response; sits between the CPU core and the ram/rom/peripherals instances.

Parameters:
ADDR_WIDTH, 16, CPU address width.
DATA_WIDTH, 16, data width; write_mask is DATA_WIDTH/8 bits.
BANK_BITS, 2, bank select bits, taken from address[ADDR_WIDTH-1 -: BANK_BITS]; NUM_BANKS = 2^BANK_BITS.
BANK_WAIT, 16'h0000, packed 4 bits per bank; bank b's wait count is BANK_WAIT[4b+3:4b].
BANK_RO, 4'b0010, bit b = 1 makes bank b read-only (default: bank 1 is ROM).
TIMEOUT, 255, maximum ACCESS cycles before abort, range 0-255; 0 disables the timeout.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
bus_enable  input  1  CPU access request, sampled only in IDLE
write_enable  input  1  1 = write, 0 = read
address  input  ADDR_WIDTH  CPU address
data_in  input  DATA_WIDTH  CPU write data
write_mask  input  DATA_WIDTH/8  byte lane enables
data_out  output  DATA_WIDTH  read data, valid when ready=1
ready  output  1  one-cycle completion pulse
bus_error  output  1  valid with ready: timeout or write to RO bank
bank_sel  output  NUM_BANKS  one-hot, held for the whole access
bank_address  output  ADDR_WIDTH-BANK_BITS  latched offset within the bank
bank_data_in  output  DATA_WIDTH  latched write data, shared by all banks
bank_write_mask  output  DATA_WIDTH/8  latched write mask
bank_write_enable  output  NUM_BANKS  one-cycle write strobe to the target bank
bank_data_out  input  NUM_BANKS*DATA_WIDTH  packed read data; bank b uses slice [b*DATA_WIDTH +: DATA_WIDTH]
bank_ready  input  NUM_BANKS  per-bank ready; tie high for synchronous BRAM

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE. All outputs are 0, including bank_sel, bank_write_enable, ready, bus_error and data_out. Counters clear.
- A reset during an access aborts it immediately: bank_sel drops, no write strobe is issued, and no ready pulse is produced.
- IDLE: on bus_enable=1, latch bank, offset, data_in, write_mask and write_enable. Load wait_cnt = BANK_WAIT[bank] and clear to_cnt. Next state is ACCESS.
- ACCESS:
  - bank_sel[bank] = 1 for every ACCESS cycle.
  - Each cycle: wait_cnt decrements until it reaches 0; to_cnt increments.
  - Completion condition: wait_cnt==0 and bank_ready[bank]==1.
  - On completion of a read, data_out latches the bank's slice of bank_data_out.
  - On completion of a write, bank_write_enable[bank] pulses during that same ACCESS cycle.
  - RO-bank write: completes on the first ACCESS cycle regardless of wait or ready. No strobe is issued, bus_error=1, and data_out is unchanged.
  - Timeout: if TIMEOUT!=0 and to_cnt reaches TIMEOUT-1 without completion, abort. No strobe is issued, data_out=0, bus_error=1.
  - Completion and timeout in the same cycle: completion wins and bus_error=0.
  - Next state is DONE.
- DONE: ready=1 for one cycle, with bus_error valid. bank_sel returns to 0. Next state is IDLE, where a new request may be accepted on the following cycle.
- Latency: with bus_enable sampled in cycle 0, ready is asserted in cycle 2 + W + R, where W is the bank's wait count and R is the number of extra cycles bank_ready stays low after the wait expires.
- CPU inputs are ignored outside IDLE; the CPU holds its request until ready.
- data_out holds its last value until the next completion.
- bus_error clears in IDLE.
- The write strobe is issued exactly once per write. It is never issued to an RO bank or on timeout.

Test Plan:
- Read bank 0, BANK_WAIT=0, bank_ready=4'hF, bank0 data 16'h1234 -> ready in cycle 2, data_out=16'h1234, bus_error=0, bank_sel=4'b0001 during cycle 1 only.
- Write 16'hBEEF to address 16'hC010 with BANK_WAIT[3]=3 -> bank_sel=4'b1000 for cycles 1-4, one bank_write_enable[3] pulse in cycle 4, bank_address=14'h0010, ready in cycle 5.
- Read bank 2 with bank_ready[2] held low 10 cycles after the wait expires -> ready in cycle 12, data captured on the cycle bank_ready rises.
- Write to bank 1 (RO) with BANK_WAIT[1]=5 -> no bank_write_enable pulse, ready in cycle 2, bus_error=1.
- TIMEOUT=8, bank_ready[2] stuck low -> ready in cycle 9, bus_error=1, data_out=0, no write strobe; next access proceeds normally.
- Assert reset low in cycle 2 of a 5-wait write -> bank_sel=0 immediately, no write strobe, no ready pulse; after release, a back-to-back access is accepted normally.

Source files
------------

// File: rtl/memory_bus_ws.sv
// Memory bus decoder: routes CPU accesses to 2^BANK_BITS banks with per-bank
// wait states, external bank ready, read-only protection and an access timeout.
module memory_bus_ws #(
    parameter int                              ADDR_WIDTH = 16,
    parameter int                              DATA_WIDTH = 16,
    parameter int                              BANK_BITS  = 2,
    parameter logic [4*(2**BANK_BITS)-1:0]     BANK_WAIT  = 16'h0000,
    parameter logic [(2**BANK_BITS)-1:0]       BANK_RO    = 4'b0010,
    parameter int                              TIMEOUT    = 255
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   bus_enable,
    input  logic                                   write_enable,
    input  logic [ADDR_WIDTH-1:0]                  address,
    input  logic [DATA_WIDTH-1:0]                  data_in,
    input  logic [DATA_WIDTH/8-1:0]                write_mask,
    output logic [DATA_WIDTH-1:0]                  data_out,
    output logic                                   ready,
    output logic                                   bus_error,
    output logic [(2**BANK_BITS)-1:0]              bank_sel,
    output logic [ADDR_WIDTH-BANK_BITS-1:0]        bank_address,
    output logic [DATA_WIDTH-1:0]                  bank_data_in,
    output logic [DATA_WIDTH/8-1:0]                bank_write_mask,
    output logic [(2**BANK_BITS)-1:0]              bank_write_enable,
    input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0]   bank_data_out,
    input  logic [(2**BANK_BITS)-1:0]              bank_ready
);

    localparam int NUM_BANKS = 2**BANK_BITS;
    localparam int OFF_W     = ADDR_WIDTH - BANK_BITS;
    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                  state;
    logic [BANK_BITS-1:0]    bank;
    logic                    write_op;
    logic [3:0]              wait_cnt;
    logic [7:0]              to_cnt;

    logic [BANK_BITS-1:0]    req_bank;
    logic [3:0]              req_wait;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    bank_rdy;
    logic                    ro_write;
    logic                    wait_over;
    logic                    complete;
    logic                    timed_out;

    function automatic logic [NUM_BANKS-1:0] onehot(input logic [BANK_BITS-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    assign req_bank  = address[ADDR_WIDTH-1 -: BANK_BITS];
    assign bank_rdy  = bank_ready[bank];
    assign ro_write  = write_op & BANK_RO[bank];
    assign wait_over = (wait_cnt == 4'd0);
    // An RO write is refused at once, without waiting for the bank.
    assign complete  = ro_write | (wait_over & bank_rdy);
    assign timed_out = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        req_wait = '0;
        rd_data  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (req_bank == BANK_BITS'(b)) req_wait = BANK_WAIT[4*b +: 4];
            if (bank == BANK_BITS'(b))     rd_data  = bank_data_out[DATA_WIDTH*b +: DATA_WIDTH];
        end
    end

    // The strobe must land in the same cycle the bank reports ready, so it is
    // decoded from live state rather than registered.
    always_comb begin
        bank_write_enable = '0;
        if (state == ACCESS && write_op && !ro_write && wait_over && bank_rdy)
            bank_write_enable = onehot(bank);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            bank            <= '0;
            write_op        <= 1'b0;
            wait_cnt        <= '0;
            to_cnt          <= '0;
            data_out        <= '0;
            ready           <= 1'b0;
            bus_error       <= 1'b0;
            bank_sel        <= '0;
            bank_address    <= '0;
            bank_data_in    <= '0;
            bank_write_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_enable) begin
                        bank            <= req_bank;
                        write_op        <= write_enable;
                        bank_address    <= address[OFF_W-1:0];
                        bank_data_in    <= data_in;
                        bank_write_mask <= write_mask;
                        wait_cnt        <= req_wait;
                        to_cnt          <= '0;
                        bank_sel        <= onehot(req_bank);
                        state           <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (complete) begin
                        // Completion beats a timeout that expires in the same cycle.
                        ready     <= 1'b1;
                        bus_error <= ro_write;
                        if (!write_op) data_out <= rd_data;
                        bank_sel  <= '0;
                        state     <= DONE;
                    end else if (timed_out) begin
                        ready     <= 1'b1;
                        bus_error <= 1'b1;
                        data_out  <= '0;
                        bank_sel  <= '0;
                        state     <= DONE;
                    end else begin
                        if (!wait_over) wait_cnt <= wait_cnt - 4'd1;
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                DONE: begin
                    ready     <= 1'b0;
                    bus_error <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_ws.sv
// Scoreboard bench for memory_bus_ws: two instances (long and short timeout),
// directed accesses push expected responses; a monitor checks each ready pulse.
module tb_memory_bus_ws;

    typedef struct {
        int          inst;
        int          issue;
        int          lat;
        logic [15:0] data;
        logic        err;
        logic [3:0]  sel;
        int          sel_cycles;
        logic [3:0]  we;
        int          we_cyc;
        logic [13:0] addr;
        logic [15:0] wdata;
        logic [1:0]  mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_enable        [2];
    logic        write_enable      [2];
    logic [15:0] address           [2];
    logic [15:0] data_in           [2];
    logic [1:0]  write_mask        [2];
    logic [15:0] data_out          [2];
    logic        ready             [2];
    logic        bus_error         [2];
    logic [3:0]  bank_sel          [2];
    logic [13:0] bank_address      [2];
    logic [15:0] bank_data_in      [2];
    logic [1:0]  bank_write_mask   [2];
    logic [3:0]  bank_write_enable [2];
    logic [63:0] bank_data_out;
    logic [3:0]  bank_ready;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_bus_ws #(.BANK_WAIT(16'h3050), .BANK_RO(4'b0010), .TIMEOUT(255)) dut0 (
        .clk(clk), .reset(reset),
        .bus_enable(bus_enable[0]), .write_enable(write_enable[0]),
        .address(address[0]), .data_in(data_in[0]), .write_mask(write_mask[0]),
        .data_out(data_out[0]), .ready(ready[0]), .bus_error(bus_error[0]),
        .bank_sel(bank_sel[0]), .bank_address(bank_address[0]),
        .bank_data_in(bank_data_in[0]), .bank_write_mask(bank_write_mask[0]),
        .bank_write_enable(bank_write_enable[0]),
        .bank_data_out(bank_data_out), .bank_ready(bank_ready)
    );

    memory_bus_ws #(.BANK_WAIT(16'h0500), .BANK_RO(4'b0010), .TIMEOUT(8)) dut1 (
        .clk(clk), .reset(reset),
        .bus_enable(bus_enable[1]), .write_enable(write_enable[1]),
        .address(address[1]), .data_in(data_in[1]), .write_mask(write_mask[1]),
        .data_out(data_out[1]), .ready(ready[1]), .bus_error(bus_error[1]),
        .bank_sel(bank_sel[1]), .bank_address(bank_address[1]),
        .bank_data_in(bank_data_in[1]), .bank_write_mask(bank_write_mask[1]),
        .bank_write_enable(bank_write_enable[1]),
        .bank_data_out(bank_data_out), .bank_ready(bank_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input int inst, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [1:0] mask);
        bus_enable[inst]   = 1'b1;
        write_enable[inst] = wr;
        address[inst]      = addr;
        data_in[inst]      = wdata;
        write_mask[inst]   = mask;
    endtask

    task automatic access(input int inst, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [1:0] mask,
                          input int lat, input logic [15:0] e_data, input logic e_err,
                          input logic [3:0] e_sel, input int e_sel_cycles,
                          input logic [3:0] e_we, input int e_we_cyc);
        exp_t e;
        start_req(inst, wr, addr, wdata, mask);
        e.inst = inst;       e.issue = cyc;         e.lat = lat;
        e.data = e_data;     e.err = e_err;         e.sel = e_sel;
        e.sel_cycles = e_sel_cycles;                e.we = e_we;
        e.we_cyc = e_we_cyc; e.addr = addr[13:0];   e.wdata = wdata;
        e.mask = mask;
        q.push_back(e);
        tick();
        bus_enable[inst] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (q.size() != 0) begin
            check("response_timeout_pending", q.size(), 0);
            q.delete();
        end
    endtask

    // Monitor: accumulate bank-side activity per access, compare on each ready.
    initial begin
        logic [3:0]  sel_or, we_or;
        int          sel_cnt, we_cnt, we_at;
        logic [13:0] sel_addr;
        logic [15:0] we_data;
        logic [1:0]  we_mask;
        exp_t        e;
        sel_or = '0; we_or = '0; sel_cnt = 0; we_cnt = 0; we_at = 0;
        sel_addr = '0; we_data = '0; we_mask = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sel_or = '0; we_or = '0; sel_cnt = 0; we_cnt = 0; we_at = 0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (bank_sel[i] != 4'd0) begin
                        if (sel_cnt == 0) sel_addr = bank_address[i];
                        sel_or |= bank_sel[i];
                        sel_cnt++;
                    end
                    if (bank_write_enable[i] != 4'd0) begin
                        we_or  |= bank_write_enable[i];
                        we_cnt++;
                        we_data = bank_data_in[i];
                        we_mask = bank_write_mask[i];
                        we_at   = (q.size() != 0) ? cyc - q[0].issue : -1;
                    end
                    if (ready[i]) begin
                        if (q.size() == 0 || q[0].inst != i) begin
                            check($sformatf("spurious_ready_dut%0d", i), 32'(ready[i]), 0);
                        end else begin
                            e = q.pop_front();
                            check("ready_latency",   cyc - e.issue, e.lat);
                            check("data_out",        data_out[i], e.data);
                            check("bus_error",       bus_error[i], e.err);
                            check("bank_sel_mask",   sel_or, e.sel);
                            check("bank_sel_cycles", sel_cnt, e.sel_cycles);
                            check("bank_address",    sel_addr, e.addr);
                            check("write_strobe",    we_or, e.we);
                            check("strobe_count",    we_cnt, (e.we != 4'd0) ? 1 : 0);
                            if (e.we != 4'd0) begin
                                check("strobe_cycle",    we_at, e.we_cyc);
                                check("bank_data_in",    we_data, e.wdata);
                                check("bank_write_mask", we_mask, e.mask);
                            end
                        end
                        sel_or = '0; we_or = '0; sel_cnt = 0; we_cnt = 0; we_at = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset         = 1'b0;
        bank_ready    = 4'hF;
        bank_data_out = {16'h4444, 16'hA5A5, 16'h2222, 16'h1234};
        for (int i = 0; i < 2; i++) begin
            bus_enable[i] = 1'b0; write_enable[i] = 1'b0; address[i] = '0;
            data_in[i] = '0; write_mask[i] = '0;
        end
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_data_out_%0d", i),  data_out[i], 0);
            check($sformatf("reset_ready_%0d", i),     ready[i], 0);
            check($sformatf("reset_bus_error_%0d", i), bus_error[i], 0);
            check($sformatf("reset_bank_sel_%0d", i),  bank_sel[i], 0);
            check($sformatf("reset_bank_we_%0d", i),   bank_write_enable[i], 0);
            check($sformatf("reset_bank_addr_%0d", i), bank_address[i], 0);
        end
        reset = 1'b1;

        // dut0: zero-wait read of bank 0
        access(0, 1'b0, 16'h0042, 16'h0000, 2'b00, 2, 16'h1234, 1'b0, 4'b0001, 1, 4'b0000, 0);
        wait_done(40);
        // dut0: write to bank 3, three wait states
        access(0, 1'b1, 16'hC010, 16'hBEEF, 2'b11, 5, 16'h1234, 1'b0, 4'b1000, 4, 4'b1000, 4);
        wait_done(40);
        // dut0: bank 2 read, bank_ready low for 10 cycles; data changes when ready rises
        bank_ready = 4'b1011;
        bank_data_out[47:32] = 16'hDEAD;
        access(0, 1'b0, 16'h8ABC, 16'h0000, 2'b00, 12, 16'h5A5A, 1'b0, 4'b0100, 11, 4'b0000, 0);
        repeat (10) tick();
        bank_ready = 4'hF;
        bank_data_out[47:32] = 16'h5A5A;
        wait_done(40);
        // dut0: write to RO bank 1 (wait 5 ignored), data_out unchanged
        access(0, 1'b1, 16'h4100, 16'h7777, 2'b01, 2, 16'h5A5A, 1'b1, 4'b0010, 1, 4'b0000, 0);
        wait_done(40);
        // dut0: read of RO bank 1 honours its five wait states
        access(0, 1'b0, 16'h4004, 16'h0000, 2'b00, 7, 16'h2222, 1'b0, 4'b0010, 6, 4'b0000, 0);
        wait_done(40);

        // dut1 (TIMEOUT=8): normal read
        access(1, 1'b0, 16'h0001, 16'h0000, 2'b00, 2, 16'h1234, 1'b0, 4'b0001, 1, 4'b0000, 0);
        wait_done(40);
        // dut1: write to bank 2 with ready stuck low -> timeout
        bank_ready = 4'b1011;
        access(1, 1'b1, 16'h8020, 16'h1111, 2'b11, 9, 16'h0000, 1'b1, 4'b0100, 8, 4'b0000, 0);
        wait_done(40);
        bank_ready = 4'hF;
        // dut1: next access after timeout proceeds normally
        access(1, 1'b0, 16'h0002, 16'h0000, 2'b00, 2, 16'h1234, 1'b0, 4'b0001, 1, 4'b0000, 0);
        wait_done(40);
        // dut1: ready rises on the timeout cycle -> completion wins
        bank_ready = 4'b1011;
        access(1, 1'b0, 16'h8030, 16'h0000, 2'b00, 9, 16'h0F0F, 1'b0, 4'b0100, 8, 4'b0000, 0);
        repeat (7) tick();
        bank_ready = 4'hF;
        bank_data_out[47:32] = 16'h0F0F;
        wait_done(40);

        // dut1: reset in cycle 2 of a five-wait write
        start_req(1, 1'b1, 16'h8040, 16'h3333, 2'b11);
        tick();
        bus_enable[1] = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("abort_bank_sel",  bank_sel[1], 0);
        check("abort_write_en",  bank_write_enable[1], 0);
        check("abort_ready",     ready[1], 0);
        check("abort_data_out",  data_out[1], 0);
        tick();
        tick();
        reset = 1'b1;
        // back-to-back accesses right after reset release
        access(1, 1'b1, 16'hFFFE, 16'hCAFE, 2'b10, 2, 16'h0000, 1'b0, 4'b1000, 1, 4'b1000, 1);
        wait_done(40);
        access(1, 1'b0, 16'hC000, 16'h0000, 2'b00, 2, 16'h4444, 1'b0, 4'b1000, 1, 4'b0000, 0);
        wait_done(40);

        repeat (10) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
